// File: rtl/sm4_round_engine_if.sv
// sm4_round_engine_if: block-in, round-key port and result-out signals of sm4_round_engine.
// RPC must match the engine's ROUNDS_PER_CYCLE; it sizes the round-key lanes.
interface sm4_round_engine_if #(parameter int RPC = 1);
  logic in_valid_i;
  logic in_ready_o;
  logic [1:0] op_i;
  logic [127:0] data_i;
  logic [4:0] rk_base_o;
  logic [32*RPC-1:0] rk_i;
  logic rk_wr_o;
  logic [4:0] rk_wr_idx_o;
  logic [32*RPC-1:0] rk_wr_data_o;
  logic out_valid_o;
  logic out_ready_i;
  logic [127:0] out_data_o;
  logic err_o;
  modport master (
    output in_valid_i, op_i, data_i, rk_i, out_ready_i,
    input in_ready_o, rk_base_o, rk_wr_o, rk_wr_idx_o, rk_wr_data_o, out_valid_o, out_data_o, err_o
  );
  modport slave (
    input in_valid_i, op_i, data_i, rk_i, out_ready_i,
    output in_ready_o, rk_base_o, rk_wr_o, rk_wr_idx_o, rk_wr_data_o, out_valid_o, out_data_o, err_o
  );
endinterface

// File: rtl/sm4_round_engine.sv
// sm4_round_engine: iterative SM4 encrypt/decrypt/key-expansion core, ROUNDS_PER_CYCLE rounds per clock.
// Key expansion (op 10) and its CK/L' logic exist only when SM4_KEYEXP_EN is defined.
module sm4_round_engine #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input logic clk_i,
  input logic rst_i,
  sm4_round_engine_if.slave bus
);
  localparam int RPC = ROUNDS_PER_CYCLE;
  if (RPC != 1 && RPC != 2 && RPC != 4 && RPC != 8) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [1:0] {M_ENC, M_DEC, M_KEX} mode_e;
  localparam logic [127:0] FK = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;
  localparam logic [0:255][7:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };
  function automatic logic [31:0] rol(input logic [31:0] a, input int n);
    return (a << n) | (a >> (32 - n));
  endfunction
  function automatic logic [31:0] tau(input logic [31:0] a);
    return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
  endfunction
  function automatic logic [31:0] lin(input logic [31:0] b);
    return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
  endfunction
`ifdef SM4_KEYEXP_EN
  function automatic logic [31:0] lin_k(input logic [31:0] b);
    return b ^ rol(b, 13) ^ rol(b, 23);
  endfunction
  // CK byte b of round i is (4i+b)*7 mod 256; the 8-bit product truncates the modulo for free
  function automatic logic [31:0] ck(input logic [4:0] i);
    logic [31:0] c;
    c = '0;
    for (int b = 0; b < 4; b++) c[31-8*b -: 8] = {1'b0, i, 2'(b)} * 8'd7;
    return c;
  endfunction
`endif
  state_e state_q, state_d;
  mode_e mode_q, mode_d, mode_acc;
  logic err_q, err_d, err_acc;
  logic [4:0] r_q, r_d;
  logic [0:3][31:0] x_q, x_d;
  logic [0:RPC+3][31:0] xc;
  logic run, done, kex;
  always_comb begin
    mode_acc = bus.op_i == 2'b01 ? M_DEC : M_ENC;
    err_acc = bus.op_i[1];
`ifdef SM4_KEYEXP_EN
    if (bus.op_i == 2'b10) begin
      mode_acc = M_KEX;
      err_acc = 1'b0;
    end
`endif
  end
  // RPC rounds chained combinationally; xc[j+4] is X_{r+j+4}
  always_comb begin
    logic [31:0] k;
    k = '0;
    xc = '0;
    xc[0:3] = x_q;
    for (int j = 0; j < RPC; j++) begin
      k = mode_q == M_DEC ? bus.rk_i[32*(RPC-1-j) +: 32] : bus.rk_i[32*j +: 32];
`ifdef SM4_KEYEXP_EN
      xc[j+4] = mode_q == M_KEX ? xc[j] ^ lin_k(tau(xc[j+1] ^ xc[j+2] ^ xc[j+3] ^ ck(5'(r_q + 5'(j)))))
                                : xc[j] ^ lin(tau(xc[j+1] ^ xc[j+2] ^ xc[j+3] ^ k));
`else
      xc[j+4] = xc[j] ^ lin(tau(xc[j+1] ^ xc[j+2] ^ xc[j+3] ^ k));
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    err_d = err_q;
    r_d = r_q;
    x_d = x_q;
    if (state_q == IDLE && bus.in_valid_i) begin
      state_d = RUN;
      mode_d = mode_acc;
      err_d = err_acc;
      r_d = '0;
      x_d = bus.data_i ^ (mode_acc == M_KEX ? FK : '0);
    end else if (state_q == RUN) begin
      x_d = xc[RPC:RPC+3];
      r_d = r_q + 5'(RPC);
      state_d = r_q == 5'(32 - RPC) ? DONE : RUN;
    end else if (state_q == DONE && bus.out_ready_i) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mode_q <= M_ENC;
      err_q <= 1'b0;
      r_q <= '0;
      x_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      err_q <= err_d;
      r_q <= r_d;
      x_q <= x_d;
    end
  end
  // outputs are gated by rst_i so a reset cycle never exposes the discarded block
  assign run = state_q == RUN && !rst_i;
  assign done = state_q == DONE && !rst_i;
  assign kex = mode_q == M_KEX;
  assign bus.in_ready_o = state_q == IDLE && !rst_i;
  assign bus.out_valid_o = done;
  assign bus.err_o = done && err_q;
  assign bus.out_data_o = !done ? '0 : kex ? x_q : {x_q[3], x_q[2], x_q[1], x_q[0]};
  assign bus.rk_base_o = !run || kex ? '0 : mode_q == M_DEC ? 5'(32 - RPC) - r_q : r_q;
`ifdef SM4_KEYEXP_EN
  logic [32*RPC-1:0] wr_data;
  always_comb begin
    wr_data = '0;
    for (int j = 0; j < RPC; j++) wr_data[32*j +: 32] = xc[j+4];
  end
  assign bus.rk_wr_o = run && kex;
  assign bus.rk_wr_idx_o = bus.rk_wr_o ? r_q : '0;
  assign bus.rk_wr_data_o = bus.rk_wr_o ? wr_data : '0;
`else
  assign bus.rk_wr_o = 1'b0;
  assign bus.rk_wr_idx_o = '0;
  assign bus.rk_wr_data_o = '0;
`endif
endmodule
